// File: rtl/noc_pkg.sv
// Shared mesh-router constants: flit field positions, output direction indices, default width.
// Pure declarations; no logic, no latency, no flow control.
package noc_pkg;
    localparam int DATA_WIDTH_DEF = 64;

    localparam int VC_BIT    = 63;
    localparam int DIR_X_BIT = 62;
    localparam int DIR_Y_BIT = 61;
    localparam int HOP_X_LSB = 52;
    localparam int HOP_Y_LSB = 48;
    localparam int HOP_W     = 4;

    localparam int DIR_N    = 0;
    localparam int DIR_S    = 1;
    localparam int DIR_E    = 2;
    localparam int DIR_W    = 3;
    localparam int DIR_PE   = 4;
    localparam int NUM_DIRS = 5;
endpackage

// File: rtl/router_input_port_if.sv
// Link + crossbar-side bundle of one router input port.
// master drives flits and grants; slave (the input port) answers with ready, requests and data.
interface router_input_port_if import noc_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  in_si;
    logic                  in_ri;
    logic [DATA_WIDTH-1:0] in_di;
    logic                  req_n;
    logic                  req_s;
    logic                  req_e;
    logic                  req_w;
    logic                  req_pe;
    logic                  gnt;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output in_si, in_di, gnt,
        input  in_ri, req_n, req_s, req_e, req_w, req_pe, data_out
    );

    modport slave (
        input  in_si, in_di, gnt,
        output in_ri, req_n, req_s, req_e, req_w, req_pe, data_out
    );
endinterface

// File: rtl/vc_fifo.sv
// Per-VC circular flit buffer with occupancy counter; head is visible combinationally.
// Latency: pushed flit becomes head the cycle after the push edge; push when full / pop when empty are ignored.
module vc_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_cnt == CNT_W'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Explicit wrap keeps DEPTH=1 correct where the pointer is wider than needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            r_cnt <= r_cnt + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end
endmodule

// File: rtl/router_input_port.sv
// Mesh-router input port: two polarity-interleaved VC buffers plus XY route computation on the draining VC.
// Latency: flit accepted at edge t requests in the next cycle whose polarity equals its VC; in_ri drops while the link VC is full.
module router_input_port import noc_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    router_input_port_if.slave bus,
    output logic              err_vc
);
    logic                  w_full0, w_full1;
    logic                  w_empty0, w_empty1;
    logic [DATA_WIDTH-1:0] w_head0, w_head1;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_head_vld;
    logic [HOP_W-1:0]      w_hop_x, w_hop_y;
    logic                  w_accept;
    logic                  w_vc_ok;
    logic                  w_push;
    logic                  w_pop;
    logic [NUM_DIRS-1:0]   w_req;
    logic [DATA_WIDTH-1:0] w_data_out;
    logic                  r_err_vc;

    // VC ~polarity faces the link, VC polarity drains toward the crossbar.
    assign bus.in_ri = polarity ? !w_full0 : !w_full1;
    assign w_accept  = bus.in_si && bus.in_ri;
    assign w_vc_ok   = (bus.in_di[VC_BIT] == ~polarity);
    assign w_push    = w_accept && w_vc_ok;
    assign w_pop     = bus.gnt && (|w_req);

    vc_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_vc0 (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push && polarity),
        .i_pop   (w_pop && !polarity),
        .i_din   (bus.in_di),
        .o_full  (w_full0),
        .o_empty (w_empty0),
        .o_head  (w_head0)
    );

    vc_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_vc1 (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push && !polarity),
        .i_pop   (w_pop && polarity),
        .i_din   (bus.in_di),
        .o_full  (w_full1),
        .o_empty (w_empty1),
        .o_head  (w_head1)
    );

    assign w_head     = polarity ? w_head1 : w_head0;
    assign w_head_vld = polarity ? !w_empty1 : !w_empty0;
    assign w_hop_x    = w_head[HOP_X_LSB +: HOP_W];
    assign w_hop_y    = w_head[HOP_Y_LSB +: HOP_W];

    // XY routing: exhaust X hops first, then Y, then eject to the local PE.
    always_comb begin
        w_req      = '0;
        w_data_out = '0;
        if (w_head_vld) begin
            w_data_out = w_head;
            if (w_hop_x != '0) begin
                w_req[w_head[DIR_X_BIT] ? DIR_W : DIR_E] = 1'b1;
                w_data_out[HOP_X_LSB +: HOP_W] = w_hop_x - 4'd1;
            end else if (w_hop_y != '0) begin
                w_req[w_head[DIR_Y_BIT] ? DIR_S : DIR_N] = 1'b1;
                w_data_out[HOP_Y_LSB +: HOP_W] = w_hop_y - 4'd1;
            end else begin
                w_req[DIR_PE] = 1'b1;
            end
        end
    end

    assign bus.req_n    = w_req[DIR_N];
    assign bus.req_s    = w_req[DIR_S];
    assign bus.req_e    = w_req[DIR_E];
    assign bus.req_w    = w_req[DIR_W];
    assign bus.req_pe   = w_req[DIR_PE];
    assign bus.data_out = w_data_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_vc <= 1'b0;
        end else if (w_accept && !w_vc_ok) begin
            r_err_vc <= 1'b1;
        end
    end

    assign err_vc = r_err_vc;
endmodule

// File: tb/tb_router_input_port.sv
// Randomized + directed bench for router_input_port against a queue-based behavioural model.
module tb_router_input_port;
    localparam int DW    = 64;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    logic polarity;
    logic err_vc;

    router_input_port_if #(.DATA_WIDTH(DW)) bus ();

    router_input_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .bus      (bus),
        .err_vc   (err_vc)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic        m_err   = 1'b0;
    bit          m_valid = 1'b0;

    logic        s_ri;
    logic        s_err;
    logic [4:0]  s_req;
    logic [63:0] s_dout;

    function automatic logic [63:0] mk(input logic vc, input logic dx, input logic dy,
                                       input int hx, input int hy, input logic [47:0] pl);
        logic [63:0] f;
        f = '0;
        f[63] = vc;
        f[62] = dx;
        f[61] = dy;
        f[55:52] = 4'(hx);
        f[51:48] = 4'(hy);
        f[47:0] = pl;
        return f;
    endfunction

    // Expected outputs: req bit order {pe,w,e,s,n}; forwarded flit = head minus one unit of the hop field used.
    task automatic model_outs(input logic p, output logic ri, output logic [4:0] req,
                              output logic [63:0] dout);
        logic [63:0] f;
        int occ_link;
        int occ_drain;
        occ_link  = p ? q0.size() : q1.size();
        occ_drain = p ? q1.size() : q0.size();
        ri   = (occ_link < DEPTH);
        req  = '0;
        dout = '0;
        if (occ_drain > 0) begin
            f = p ? q1[0] : q0[0];
            if (f[55:52] != 4'd0) begin
                req[f[62] ? 3 : 2] = 1'b1;
                dout = f - (64'd1 << 52);
            end else if (f[51:48] != 4'd0) begin
                req[f[61] ? 1 : 0] = 1'b1;
                dout = f - (64'd1 << 48);
            end else begin
                req[4] = 1'b1;
                dout = f;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic p, input logic si,
                         input logic [63:0] di, input logic g);
        logic        e_ri;
        logic [4:0]  e_req;
        logic [63:0] e_dout;
        reset      = r;
        polarity   = p;
        bus.in_si  = si;
        bus.in_di  = di;
        bus.gnt    = g;
        #4;
        s_ri   = bus.in_ri;
        s_req  = {bus.req_pe, bus.req_w, bus.req_e, bus.req_s, bus.req_n};
        s_dout = bus.data_out;
        s_err  = err_vc;
        model_outs(p, e_ri, e_req, e_dout);
        if (m_valid) begin
            chk("in_ri", 64'(s_ri), 64'(e_ri));
            chk("req", 64'(s_req), 64'(e_req));
            chk("data_out", s_dout, e_dout);
            chk("err_vc", 64'(s_err), 64'(m_err));
        end
        @(posedge clk);
        if (r) begin
            q0.delete();
            q1.delete();
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (g && (e_req != 5'd0)) begin
                if (p) void'(q1.pop_front());
                else   void'(q0.pop_front());
            end
            if (si && e_ri) begin
                if (di[63] == ~p) begin
                    if (p) q0.push_back(di);
                    else   q1.push_back(di);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        #1;
    endtask

    function automatic logic [63:0] rnd_flit(input logic p);
        logic [63:0] f;
        int hx;
        int hy;
        hx = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
        hy = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
        f = mk(($urandom_range(0, 9) == 0) ? p : ~p, 1'($urandom), 1'($urandom),
               hx, hy, {16'($urandom), 32'($urandom)});
        f[60:56] = 5'($urandom);
        return f;
    endfunction

    initial begin
        logic [63:0] fa, fb, fc, fd;
        logic        p;

        // Reset with in_si high: nothing is pushed and outputs sit at reset values.
        cycle(1'b1, 1'b0, 1'b1, mk(1, 0, 0, 1, 0, 48'h1), 1'b0);
        cycle(1'b1, 1'b1, 1'b1, mk(0, 0, 0, 1, 0, 48'h2), 1'b0);
        chk("rst_ri", 64'(s_ri), 64'd1);
        chk("rst_req", 64'(s_req), 64'd0);
        chk("rst_dout", s_dout, 64'd0);
        chk("rst_err", 64'(s_err), 64'd0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("no_push_in_reset", 64'(s_req), 64'd0);

        // hop_x=2 westbound
        cycle(1'b0, 1'b0, 1'b1, mk(1, 1, 0, 2, 0, 48'hA1), 1'b0);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        chk("west_req", 64'(s_req), 64'b01000);
        chk("west_hopx", 64'(s_dout[55:52]), 64'd1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("west_popped", 64'(s_req), 64'd0);

        // hop_y=3 southbound, then local eject
        cycle(1'b0, 1'b0, 1'b1, mk(1, 0, 1, 0, 3, 48'hB2), 1'b0);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        chk("south_req", 64'(s_req), 64'b00010);
        chk("south_hopy", 64'(s_dout[51:48]), 64'd2);
        fa = mk(1, 1, 1, 0, 0, 48'hC3);
        cycle(1'b0, 1'b0, 1'b1, fa, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        chk("pe_req", 64'(s_req), 64'b10000);
        chk("pe_dout", s_dout, fa);

        // Fill VC0, third flit ignored, grant reopens, order kept across wrap
        fa = mk(0, 0, 0, 1, 0, 48'hAAAA);
        fb = mk(0, 0, 0, 1, 0, 48'hBBBB);
        fc = mk(0, 0, 0, 1, 0, 48'hCCCC);
        fd = mk(0, 0, 0, 1, 0, 48'hDDDD);
        cycle(1'b0, 1'b1, 1'b1, fa, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("east_req", 64'(s_req), 64'b00100);
        cycle(1'b0, 1'b1, 1'b1, fb, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, fc, 1'b0);
        chk("full_ri", 64'(s_ri), 64'd0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("fifo_a", s_dout, mk(0, 0, 0, 0, 0, 48'hAAAA));
        cycle(1'b0, 1'b1, 1'b1, fd, 1'b0);
        chk("reopen_ri", 64'(s_ri), 64'd1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("fifo_b", s_dout, mk(0, 0, 0, 0, 0, 48'hBBBB));
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("fifo_d_wrap", s_dout, mk(0, 0, 0, 0, 0, 48'hDDDD));
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("third_dropped", 64'(s_req), 64'd0);

        // Wrong VC bit: dropped, err sticky
        cycle(1'b0, 1'b0, 1'b1, mk(0, 0, 0, 1, 1, 48'hEE), 1'b0);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("err_set", 64'(s_err), 64'd1);
        chk("err_dropped", 64'(s_req), 64'd0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("err_sticky", 64'(s_err), 64'd1);

        // Push VC1 while granting VC0 in the same cycle
        cycle(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 2, 48'h11), 1'b0);
        cycle(1'b0, 0, 1'b1, mk(1, 0, 0, 0, 0, 48'h22), 1'b1);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("same_cyc_push", 64'(s_req), 64'b10000);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("same_cyc_pop", 64'(s_req), 64'd0);

        // Both VCs full, then reset empties them
        cycle(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 1, 48'h33), 1'b0);
        cycle(1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1, 0, 48'h44), 1'b0);
        cycle(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 1, 48'h55), 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("vc1_full_ri", 64'(s_ri), 64'd0);
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("post_rst_ri1", 64'(s_ri), 64'd1);
        chk("post_rst_req1", 64'(s_req), 64'd0);
        chk("post_rst_err", 64'(s_err), 64'd0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("post_rst_ri0", 64'(s_ri), 64'd1);
        chk("post_rst_req0", 64'(s_req), 64'd0);

        // Randomized traffic
        p = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) != 0) p = ~p;
            cycle(($urandom_range(0, 199) == 0), p, ($urandom_range(0, 9) < 7),
                  rnd_flit(p), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/router_input_port.md
# router_input_port

Input stage of one mesh-router port. It buffers incoming flits per virtual channel (even/odd, selected by `polarity`) and performs XY route computation. It raises a one-hot request toward the five output-port round-robin arbiters and pops the head flit when granted. The forwarded flit carries its hop field already decremented. One instance sits between each input link (N/S/E/W/PE) and the router crossbar.

## Interface
Parameters:
- `DATA_WIDTH`, default 64: flit width.
- `DEPTH`, default 2: flits per VC buffer; power of two, ≥1.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `polarity` in 1: router phase. VC `polarity` drains internally; VC `~polarity` is open to the link.
- `in_si` in 1: upstream send-valid.
- `in_ri` out 1: ready; `!full[~polarity]`.
- `in_di` in DATA_WIDTH: incoming flit.
- `req_n`, `req_s`, `req_e`, `req_w`, `req_pe` out 1 each: one-hot request for the head of VC `polarity`.
- `gnt` in 1: OR of this port's grants from all output arbiters, same cycle as the request.
- `data_out` out DATA_WIDTH: head flit of VC `polarity` with hop decremented; 0 when no request.
- `err_vc` out 1: sticky; set when a flit arrives whose VC bit ≠ `~polarity`.

## Operation
Flit format:
- [63] VC
- [62] x-direction (0=E, 1=W)
- [61] y-direction (0=N, 1=S)
- [60:56] reserved
- [55:52] hop_x
- [51:48] hop_y
- [47:0] source/payload

Write:
- Condition: `in_si && in_ri && in_di[63]==~polarity`.
- Action: push into VC `~polarity`.
- If `in_si && in_ri` and the VC bit mismatches: drop the flit and set `err_vc`.
- `in_si` while not ready: ignored. No back-pressure violation is possible at this stage.

Route (combinational, XY, from head of VC `polarity`, only when that VC is non-empty):
- `hop_x≠0`: request E or W per [62]; `data_out` = head with `hop_x-1`.
- else `hop_y≠0`: request N or S per [61]; `data_out` = head with `hop_y-1`.
- else: `req_pe`; `data_out` = head unchanged.
- Hop arithmetic is 4-bit unsigned. Never decrement a zero field. No wrap.

Pop:
- `gnt` while a request is active pops VC `polarity` at the edge.
- `gnt` with no request: ignored.

Buffers:
- Circular, `$clog2(DEPTH)`-bit read/write pointers that wrap modulo DEPTH.
- Occupancy counter 0..DEPTH; full = DEPTH, empty = 0.
- Push and pop never target the same VC in one cycle (opposite polarities). Push to one VC and pop from the other in the same cycle are both performed.

## Timing
- Reset values:
  - all occupancies 0, pointers 0, `err_vc`=0
  - hence `in_ri`=1, all `req_*`=0, `data_out`=0
- Reset mid-operation discards all buffered flits. `err_vc` clears only on reset.
- `in_ri`, `req_*`, `data_out` are combinational from state and `polarity`. No input-to-output path from `in_si`/`in_di`.
- Latency: a flit accepted at edge t can request at the first cycle after t with `polarity==VC`. With `polarity` toggling every cycle, that is cycle t+1.
- Request is held, with `data_out` stable, until the granting edge. The next head (if any) requests at the next cycle of the same polarity.
- Full VC: `in_ri`=0 in that VC's link phase. It re-asserts the cycle after a pop frees space and polarity returns.
- `polarity` is not required to toggle. Holding it constant keeps draining one VC and filling the other.

## Structure
- Shared package `noc_pkg`:
  - flit field positions (VC, dir_x, dir_y, hop_x, hop_y)
  - direction index constants N=0, S=1, E=2, W=3, PE=4
  - `DATA_WIDTH` default
- One sub-module `vc_fifo` (push, pop, full, empty, head; occupancy counter + pointers), instantiated twice.
- Route logic and `err_vc` stay in the top module.

## Test plan
- Reset with `in_si`=1 → `in_ri`=1, all `req_*`=0, `data_out`=0, `err_vc`=0. No push while `reset`=1.
- `polarity` toggling; push VC1 flit, hop_x=2, dir_x=W, at polarity 0 → next cycle (polarity 1) `req_w`=1, `data_out[55:52]`=1. `gnt` pops it; `req_w`=0 two cycles later.
- hop_x=0, hop_y=3, dir_y=S → `req_s`, `data_out[51:48]`=2. Flit with hop_x=hop_y=0 → `req_pe`, hop bits unchanged.
- DEPTH=2: fill VC0 with two flits, withhold `gnt` → `in_ri`=0 in VC0's link phase. A third `in_si` is ignored. One grant re-opens `in_ri`; FIFO order is preserved across pointer wrap.
- Flit VC bit = polarity at the link → dropped, occupancy unchanged, `err_vc` stays 1 until reset.
- Same cycle: push VC1 while granting VC0 → both occur. Reset asserted with both VCs full → both empty next cycle.
